ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-clock `ram` block (separate read and write ports, `D_WIDTH` data, `A_WIDTH` address). Each requester issues read or write commands over a valid/ready handshake. The arbiter registers the chosen commands onto the RAM ports and routes read data back to the requester that issued the read. When one requester reads and the other writes to different addresses, both are granted in the same cycle; otherwise priority is round-robin.

---
 rtl/ram_arbiter_if.sv | 50 +++++
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes and RAM command/data signals seen by the
// ram_arbiter. The slave side is the arbiter; the master side is everything
// around it (both requesters plus the RAM).
interface ram_arbiter_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    logic               p0_req_valid;
    logic               p0_req_ready;
    logic               p0_req_we;
    logic [A_WIDTH-1:0] p0_req_addr;
    logic [D_WIDTH-1:0] p0_req_wdata;
    logic               p0_rsp_valid;
    logic [D_WIDTH-1:0] p0_rsp_data;

    logic               p1_req_valid;
    logic               p1_req_ready;
    logic               p1_req_we;
    logic [A_WIDTH-1:0] p1_req_addr;
    logic [D_WIDTH-1:0] p1_req_wdata;
    logic               p1_rsp_valid;
    logic [D_WIDTH-1:0] p1_rsp_data;

    logic               ram_write_en;
    logic [A_WIDTH-1:0] ram_write_addr;
    logic [D_WIDTH-1:0] ram_write_data;
    logic               ram_read_en;
    logic [A_WIDTH-1:0] ram_read_addr;
    logic [D_WIDTH-1:0] ram_read_data;

    modport slave (
        input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
        output p0_req_ready, p0_rsp_valid, p0_rsp_data,
        input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
        output p1_req_ready, p1_rsp_valid, p1_rsp_data,
        output ram_write_en, ram_write_addr, ram_write_data,
        output ram_read_en, ram_read_addr,
        input  ram_read_data
    );

    modport master (
        output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_data,
        output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_data,
        input  ram_write_en, ram_write_addr, ram_write_data,
        input  ram_read_en, ram_read_addr,
        output ram_read_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-clock dual-port RAM.
// A read and a write to different addresses from different ports are granted
// together; every other contention is resolved by a round-robin pointer.
// Commands are registered onto the RAM ports, and read data is steered back
// to the issuing port two cycles after acceptance.
module ram_arbiter #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    logic               w_v0;
    logic               w_v1;
    logic               w_dual;
    logic               w_g0;
    logic               w_g1;
    logic               w_wr_go;
    logic               w_wr_sel1;
    logic               w_rd_go;
    logic               w_rd_sel1;

    logic               r_prio;
    logic               r_wr_en_p1;
    logic [A_WIDTH-1:0] r_wr_addr_p1;
    logic [D_WIDTH-1:0] r_wr_data_p1;
    logic               r_rd_en_p1;
    logic [A_WIDTH-1:0] r_rd_addr_p1;
    logic               r_rd_owner_p1;
    logic               r_rsp_pend_p2;
    logic               r_rsp_owner_p2;

    // Grant decision: single requester wins outright, a read/write pair to
    // different addresses is granted together, anything else goes to prio.
    always_comb begin
        w_v0      = bus.p0_req_valid;
        w_v1      = bus.p1_req_valid;
        w_dual    = w_v0 && w_v1 &&
                    (bus.p0_req_we != bus.p1_req_we) &&
                    (bus.p0_req_addr != bus.p1_req_addr);
        w_g0      = !rst && w_v0 && (!w_v1 || w_dual || !r_prio);
        w_g1      = !rst && w_v1 && (!w_v0 || w_dual ||  r_prio);
        w_wr_sel1 = w_g1 && bus.p1_req_we;
        w_wr_go   = (w_g0 && bus.p0_req_we) || w_wr_sel1;
        w_rd_sel1 = w_g1 && !bus.p1_req_we;
        w_rd_go   = (w_g0 && !bus.p0_req_we) || w_rd_sel1;
    end

    assign bus.p0_req_ready = w_g0;
    assign bus.p1_req_ready = w_g1;

    // Round-robin pointer: a lone grant hands priority to the other port;
    // dual grants and idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_g0 != w_g1) begin
            r_prio <= w_g0;
        end
    end

    // Command stage (p1): register granted write/read onto the RAM ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en_p1    <= 1'b0;
            r_wr_addr_p1  <= '0;
            r_wr_data_p1  <= '0;
            r_rd_en_p1    <= 1'b0;
            r_rd_addr_p1  <= '0;
            r_rd_owner_p1 <= 1'b0;
        end else begin
            r_wr_en_p1 <= w_wr_go;
            if (w_wr_go) begin
                r_wr_addr_p1 <= w_wr_sel1 ? bus.p1_req_addr  : bus.p0_req_addr;
                r_wr_data_p1 <= w_wr_sel1 ? bus.p1_req_wdata : bus.p0_req_wdata;
            end
            r_rd_en_p1 <= w_rd_go;
            if (w_rd_go) begin
                r_rd_addr_p1  <= w_rd_sel1 ? bus.p1_req_addr : bus.p0_req_addr;
                r_rd_owner_p1 <= w_rd_sel1;
            end
        end
    end

    // Response stage (p2): track which port the RAM read data belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_pend_p2  <= 1'b0;
            r_rsp_owner_p2 <= 1'b0;
        end else begin
            r_rsp_pend_p2  <= r_rd_en_p1;
            r_rsp_owner_p2 <= r_rd_owner_p1;
        end
    end

    assign bus.ram_write_en   = r_wr_en_p1;
    assign bus.ram_write_addr = r_wr_addr_p1;
    assign bus.ram_write_data = r_wr_data_p1;
    assign bus.ram_read_en    = r_rd_en_p1;
    assign bus.ram_read_addr  = r_rd_addr_p1;

    // Responses are suppressed while reset is held so nothing leaks out of
    // a pipeline that is being flushed.
    assign bus.p0_rsp_valid = !rst && r_rsp_pend_p2 && !r_rsp_owner_p2;
    assign bus.p1_rsp_valid = !rst && r_rsp_pend_p2 &&  r_rsp_owner_p2;
    assign bus.p0_rsp_data  = bus.ram_read_data;
    assign bus.p1_rsp_data  = bus.ram_read_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a
// transaction-level reference model checked every cycle.
module tb_ram_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bif();

    ram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Behavioural single-clock RAM: one-cycle read latency.
    logic [DW-1:0] ram_mem [0:31] = '{default: '0};
    always @(posedge clk) begin
        if (bif.ram_write_en) ram_mem[bif.ram_write_addr] <= bif.ram_write_data;
        if (bif.ram_read_en)  bif.ram_read_data <= ram_mem[bif.ram_read_addr];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int            due;
        bit            owner;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq [$];
    bit            m_prio;
    bit            m_wen;
    bit            m_ren;
    logic [AW-1:0] m_waddr;
    logic [AW-1:0] m_raddr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_mem [0:31];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic req(bit p, bit v, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        if (!p) begin
            bif.p0_req_valid = v; bif.p0_req_we = we;
            bif.p0_req_addr  = a; bif.p0_req_wdata = d;
        end else begin
            bif.p1_req_valid = v; bif.p1_req_we = we;
            bif.p1_req_addr  = a; bif.p1_req_wdata = d;
        end
    endtask

    // Sample at the falling edge, compare DUT against the model, then advance
    // the model by what the coming rising edge will commit.
    task automatic neg();
        bit            v0, v1, we0, we1, dual, g0, g1, e0, e1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1, edata;
        @(negedge clk);
        cyc++;
        chk("ram_write_en", bif.ram_write_en, m_wen);
        if (m_wen) begin
            chk("ram_write_addr", bif.ram_write_addr, m_waddr);
            chk("ram_write_data", bif.ram_write_data, m_wdata);
        end
        chk("ram_read_en", bif.ram_read_en, m_ren);
        if (m_ren) chk("ram_read_addr", bif.ram_read_addr, m_raddr);

        v0 = bif.p0_req_valid; we0 = bif.p0_req_we; a0 = bif.p0_req_addr; d0 = bif.p0_req_wdata;
        v1 = bif.p1_req_valid; we1 = bif.p1_req_we; a1 = bif.p1_req_addr; d1 = bif.p1_req_wdata;
        g0 = 0; g1 = 0;
        if (!rst) begin
            dual = v0 && v1 && (we0 != we1) && (a0 != a1);
            if (v0 && v1 && !dual) begin
                g0 = (m_prio == 1'b0);
                g1 = !g0;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("p0_req_ready", bif.p0_req_ready, g0);
        chk("p1_req_ready", bif.p1_req_ready, g1);

        e0 = 0; e1 = 0; edata = '0;
        if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].owner) e1 = 1; else e0 = 1;
            edata = rq[0].data;
            void'(rq.pop_front());
        end
        chk("p0_rsp_valid", bif.p0_rsp_valid, e0);
        chk("p1_rsp_valid", bif.p1_rsp_valid, e1);
        if (e0) chk("p0_rsp_data", bif.p0_rsp_data, edata);
        if (e1) chk("p1_rsp_data", bif.p1_rsp_data, edata);

        if (rst) begin
            m_prio = 0; m_wen = 0; m_ren = 0;
            m_waddr = '0; m_raddr = '0; m_wdata = '0;
            rq.delete();
        end else begin
            m_wen = 0; m_ren = 0;
            if (g0 && !we0) begin m_ren = 1; m_raddr = a0; rq.push_back(rsp_t'{cyc + 2, 1'b0, m_mem[a0]}); end
            if (g1 && !we1) begin m_ren = 1; m_raddr = a1; rq.push_back(rsp_t'{cyc + 2, 1'b1, m_mem[a1]}); end
            if (g0 && we0) begin m_wen = 1; m_waddr = a0; m_wdata = d0; m_mem[a0] = d0; end
            if (g1 && we1) begin m_wen = 1; m_waddr = a1; m_wdata = d1; m_mem[a1] = d1; end
            if (g0 != g1) m_prio = g0;
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        neg();
        pos();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_prio = 0; m_wen = 0; m_ren = 0;
        m_waddr = '0; m_raddr = '0; m_wdata = '0;
        rst = 1'b1;
        req(0, 0, 0, '0, '0);
        req(1, 0, 0, '0, '0);
        pos();

        // Reset held with both requesters valid
        req(0, 1, 0, 5'h10, '0);
        req(1, 1, 0, 5'h11, '0);
        neg();
        chk("rst_ready0", bif.p0_req_ready, 0);
        chk("rst_ready1", bif.p1_req_ready, 0);
        chk("rst_read_en", bif.ram_read_en, 0);
        chk("rst_write_en", bif.ram_write_en, 0);
        pos();
        step();
        rst = 1'b0;
        neg();
        chk("first_grant_p0", bif.p0_req_ready, 1);
        chk("first_grant_p1", bif.p1_req_ready, 0);
        pos();
        req(0, 0, 0, '0, '0);
        neg();
        chk("second_grant_p1", bif.p1_req_ready, 1);
        pos();
        req(1, 0, 0, '0, '0);
        repeat (3) step();

        // Two writes contend: serialized by prio (0)
        req(0, 1, 1, 5'h01, 32'h1111_1111);
        req(1, 1, 1, 5'h02, 32'h2222_2222);
        neg();
        chk("ww_p0_first", bif.p0_req_ready, 1);
        chk("ww_p1_wait", bif.p1_req_ready, 0);
        pos();
        req(0, 0, 0, '0, '0);
        neg();
        chk("ww_p1_next", bif.p1_req_ready, 1);
        pos();
        req(1, 0, 0, '0, '0);

        // Both ports hold reads: grants alternate, responses back-to-back
        req(0, 1, 0, 5'h01, '0);
        req(1, 1, 0, 5'h02, '0);
        for (int i = 0; i < 6; i++) begin
            neg();
            chk("alt_grant_p0", bif.p0_req_ready, (i % 2 == 0) ? 1 : 0);
            chk("alt_grant_p1", bif.p1_req_ready, (i % 2 == 1) ? 1 : 0);
            if (i >= 2) begin
                chk("alt_rsp_valid0", bif.p0_rsp_valid, (i % 2 == 0) ? 1 : 0);
                chk("alt_rsp_valid1", bif.p1_rsp_valid, (i % 2 == 1) ? 1 : 0);
                chk("alt_rsp_data", bif.p0_rsp_data,
                    (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
            end
            pos();
        end
        req(0, 0, 0, '0, '0);
        req(1, 0, 0, '0, '0);
        repeat (3) step();

        // p0 write 0x10 <- 0xFF then read it back
        req(0, 1, 1, 5'h10, 32'h0000_00FF);
        neg();
        chk("wr10_ready", bif.p0_req_ready, 1);
        pos();
        req(0, 1, 0, 5'h10, '0);
        neg();
        chk("rd10_ready", bif.p0_req_ready, 1);
        chk("wr10_write_en", bif.ram_write_en, 1);
        pos();
        req(0, 0, 0, '0, '0);
        neg();
        chk("rd10_read_en", bif.ram_read_en, 1);
        pos();
        neg();
        chk("rd10_rsp_valid0", bif.p0_rsp_valid, 1);
        chk("rd10_rsp_data", bif.p0_rsp_data, 32'h0000_00FF);
        chk("rd10_rsp_valid1", bif.p1_rsp_valid, 0);
        pos();
        repeat (2) step();

        // Dual grant: p0 reads 0x03 while p1 writes 0x07 <- 0xA5 (prio is 1)
        req(0, 1, 0, 5'h03, '0);
        req(1, 1, 1, 5'h07, 32'h0000_00A5);
        neg();
        chk("dual_ready0", bif.p0_req_ready, 1);
        chk("dual_ready1", bif.p1_req_ready, 1);
        pos();
        req(0, 0, 0, '0, '0);
        req(1, 0, 0, '0, '0);
        neg();
        chk("dual_write_en", bif.ram_write_en, 1);
        chk("dual_read_en", bif.ram_read_en, 1);
        chk("dual_write_addr", bif.ram_write_addr, 5'h07);
        chk("dual_read_addr", bif.ram_read_addr, 5'h03);
        pos();
        repeat (3) step();

        // Same address read/write with prio still 1: write first, read sees new data
        req(1, 1, 1, 5'h04, 32'h0000_0011);
        req(0, 1, 0, 5'h04, '0);
        neg();
        chk("raw_write_first", bif.p1_req_ready, 1);
        chk("raw_read_waits", bif.p0_req_ready, 0);
        pos();
        req(1, 0, 0, '0, '0);
        neg();
        chk("raw_read_next", bif.p0_req_ready, 1);
        pos();
        req(0, 0, 0, '0, '0);
        step();
        neg();
        chk("raw_rsp_valid0", bif.p0_rsp_valid, 1);
        chk("raw_rsp_data", bif.p0_rsp_data, 32'h0000_0011);
        pos();
        repeat (2) step();

        // Read accepted, reset pulsed next cycle: response dropped, prio back to 0
        req(0, 1, 0, 5'h10, '0);
        neg();
        chk("rstmid_read_ready", bif.p0_req_ready, 1);
        pos();
        req(0, 0, 0, '0, '0);
        rst = 1'b1;
        neg();
        chk("rstmid_ready0", bif.p0_req_ready, 0);
        pos();
        rst = 1'b0;
        req(0, 1, 0, 5'h01, '0);
        req(1, 1, 0, 5'h02, '0);
        neg();
        chk("rstmid_no_rsp0", bif.p0_rsp_valid, 0);
        chk("rstmid_no_rsp1", bif.p1_rsp_valid, 0);
        chk("rstmid_read_en", bif.ram_read_en, 0);
        chk("rstmid_grant_p0", bif.p0_req_ready, 1);
        chk("rstmid_wait_p1", bif.p1_req_ready, 0);
        pos();
        req(0, 0, 0, '0, '0);
        neg();
        chk("rstmid_grant_p1", bif.p1_req_ready, 1);
        pos();
        req(1, 0, 0, '0, '0);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
